serial_shift_ctrl: RTL
======================

SERIAL_SHIFT_CTRL -- requirements
Module: serial_shift_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the datapath register width and the number of shifts per word (N >= 1).
REQ-002 The block SHALL have parameter CW, default 3, giving the bit_cnt width; CW SHALL satisfy 2^CW > N.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 start  input  1  request to load and serialize one word.
REQ-006 msb  input  1  MSB of the controlled shift register's parallel output (pout[N-1]).
REQ-007 ld  output  1  parallel-load command to the shift register.
REQ-008 shl  output  1  shift-left command to the shift register.
REQ-009 sout  output  1  serial data bit.
REQ-010 sout_valid  output  1  sout carries a valid bit this cycle.
REQ-011 busy  output  1  high while a word is in progress (LOAD, SHIFT or DONE).
REQ-012 done  output  1  one-cycle pulse at word completion.
REQ-013 bit_cnt  output  CW  number of shifts completed in the current word.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, LOAD, SHIFT and DONE; all outputs except sout SHALL be decoded from the registered state (Moore).
REQ-015 IDLE: ld=0, shl=0, busy=0, done=0; start=1 moves the FSM to LOAD; otherwise it stays in IDLE.
REQ-016 LOAD: ld=1 for exactly one cycle, bit_cnt cleared to 0; the FSM moves unconditionally to SHIFT.
REQ-017 SHIFT: shl=1 and sout_valid=1 every cycle; bit_cnt increments by 1 on each edge leaving a SHIFT cycle.
REQ-018 SHIFT SHALL last exactly N cycles; the FSM moves to DONE on the edge where bit_cnt equals N-1.
REQ-019 DONE: done=1 for one cycle and bit_cnt holds N; start=1 moves the FSM directly to LOAD (back-to-back), otherwise to IDLE.
REQ-020 sout SHALL equal msb combinationally when sout_valid=1, and SHALL be 0 otherwise.
REQ-021 ld and shl SHALL never be 1 in the same cycle.
REQ-022 start SHALL be ignored in LOAD and SHIFT; no request is queued.
REQ-023 Latency: when start is sampled high in IDLE at edge k, ld is high in cycle k+1, shl in cycles k+2..k+N+1, and done in cycle k+N+2.
REQ-024 Back-to-back throughput SHALL be one word per N+2 cycles.
REQ-025 With N=1, SHIFT SHALL last exactly one cycle and bit_cnt SHALL go 0 -> 1.
REQ-026 bit_cnt SHALL hold its value in IDLE.

Reset
REQ-027 When rst=1 at a clock edge, the FSM SHALL enter IDLE and bit_cnt SHALL be 0, so that ld, shl, sout, sout_valid, busy and done are all 0 in the following cycle.
REQ-028 rst SHALL take priority over start and over every state transition, including a reset during SHIFT or DONE.
REQ-029 Reset SHALL abort a word in progress: no done pulse is generated and no further shl is issued.

Verification
REQ-030 N=4, datapath loaded with 0101, one-cycle start pulse -> ld for 1 cycle, then 4 shl cycles with sout = 0,1,0,1, then done for 1 cycle, then IDLE with busy=0.
REQ-031 N=4, start held high continuously -> repeating ld, shl x4, done pattern with a period of 6 cycles and no idle gap between words.
REQ-032 start pulsed during the 2nd SHIFT cycle -> ignored, and exactly one done pulse follows.
REQ-033 rst asserted during the 3rd SHIFT cycle -> next cycle all outputs are 0, bit_cnt=0, and no done pulse occurs.
REQ-034 N=1, start pulse -> ld, one shl cycle with sout=msb, done; bit_cnt reads 1 in DONE.
REQ-035 Every scenario -> ld and shl are never both 1, and done is never high for more than one consecutive cycle.

Source files
------------

// File: rtl/serial_shift_ctrl_if.sv
// serial_shift_ctrl_if: handshake bundle between a shift-register controller and its user.
//   start/msb      : request and shift-register MSB, driven by the master
//   ld/shl         : load / shift-left commands to the shift register
//   sout/sout_valid: serial bit and its qualifier
//   busy/done      : word in progress / one-cycle completion pulse
//   bit_cnt        : shifts completed in the current word
interface serial_shift_ctrl_if #(parameter int CW = 3);
   logic start, msb, ld, shl, sout, sout_valid, busy, done;
   logic [CW-1:0] bit_cnt;
   modport master(output start, msb, input ld, shl, sout, sout_valid, busy, done, bit_cnt);
   modport slave(input start, msb, output ld, shl, sout, sout_valid, busy, done, bit_cnt);
endinterface

// File: rtl/serial_shift_ctrl.sv
// serial_shift_ctrl: Moore FSM that loads an N-bit shift register and shifts it out MSB first.
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset
//   ctrl_if : slave side of serial_shift_ctrl_if (start/msb in; ld, shl, sout, sout_valid,
//             busy, done, bit_cnt out)
module serial_shift_ctrl #(
   parameter int N  = 4,
   parameter int CW = 3
) (
   input logic clk,
   input logic rst,
   serial_shift_ctrl_if.slave ctrl_if
);
   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic ld_q, shl_q, busy_q, done_q;
   logic last;
   assign last = cnt_q == CW'(N - 1);
   // Counter clears on entry to LOAD so it reads 0 throughout LOAD and the first shift,
   // and holds N in DONE and afterwards in IDLE.
   always_comb begin
      state_d = state_q == IDLE  ? (ctrl_if.start ? LOAD : IDLE) :
                state_q == LOAD  ? SHIFT :
                state_q == SHIFT ? (last ? DONE : SHIFT) :
                                   (ctrl_if.start ? LOAD : IDLE);
      cnt_d = state_d == LOAD ? '0 : state_q == SHIFT ? cnt_q + 1'b1 : cnt_q;
   end
   // Outputs are decoded from the next state so they are registered alongside it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ld_q    <= 1'b0;
         shl_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ld_q    <= state_d == LOAD;
         shl_q   <= state_d == SHIFT;
         busy_q  <= state_d != IDLE;
         done_q  <= state_d == DONE;
      end
   end
   assign ctrl_if.ld         = ld_q;
   assign ctrl_if.shl        = shl_q;
   assign ctrl_if.sout_valid = shl_q;
   assign ctrl_if.sout       = shl_q & ctrl_if.msb;
   assign ctrl_if.busy       = busy_q;
   assign ctrl_if.done       = done_q;
   assign ctrl_if.bit_cnt    = cnt_q;
endmodule
